// File: rtl/sad_min_tracker.sv
// Tail of the SAD pipeline: walks the search window in raster order as SAD sums retire
// and keeps the smallest sum plus the (row, col) position where it first appeared.
module sad_min_tracker #(
  parameter int SUM_W    = 32,
  parameter int IDX_W    = 8,
  parameter int NUM_COLS = 61,
  parameter int NUM_ROWS = 61,
  parameter int CNT_W    = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Abort,
  input  logic             SumValid,
  input  logic [SUM_W-1:0] Sum,
  output logic             Busy,
  output logic             Done,
  output logic [SUM_W-1:0] MinSum,
  output logic [IDX_W-1:0] MinRow,
  output logic [IDX_W-1:0] MinCol,
  output logic [CNT_W-1:0] Count
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [IDX_W-1:0] LastCol = IDX_W'(NUM_COLS - 1);
  localparam logic [IDX_W-1:0] LastRow = IDX_W'(NUM_ROWS - 1);

  state_t           state;
  logic [IDX_W-1:0] row;
  logic [IDX_W-1:0] col;

  assign Busy = (state == SCAN);
  assign Done = (state == DONE);

  // NOTE: every register below is updated with <= so all of them see the pre-edge
  // values of row/col/MinSum; blocking assignments here would make the compare and
  // the position capture depend on statement order.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state  <= IDLE;
      MinSum <= '1;
      MinRow <= '0;
      MinCol <= '0;
      Count  <= '0;
      row    <= '0;
      col    <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (Start) begin
            state  <= SCAN;
            MinSum <= '1;
            MinRow <= '0;
            MinCol <= '0;
            Count  <= '0;
            row    <= '0;
            col    <= '0;
          end else begin
            state <= IDLE;
          end
        end

        SCAN: begin
          // Abort wins over a coincident sample, which is simply dropped.
          if (Abort) begin
            state <= IDLE;
          end else if (SumValid) begin
            // Strict compare: ties keep the earlier position, all-ones never replaces.
            if (Sum < MinSum) begin
              MinSum <= Sum;
              MinRow <= row;
              MinCol <= col;
            end
            if (Count != '1) Count <= Count + CNT_W'(1);
            if (col == LastCol) begin
              col <= '0;
              if (row == LastRow) begin
                row   <= '0;
                state <= DONE;
              end else begin
                row <= row + IDX_W'(1);
              end
            end else begin
              col <= col + IDX_W'(1);
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sad_min_tracker.sv
// Scoreboard bench for sad_min_tracker on a 3x2 window: every Busy edge (scan start or
// scan end) pops one expected result record pushed by the stimulus process.
module tb_sad_min_tracker;

  localparam int SUM_W    = 32;
  localparam int IDX_W    = 8;
  localparam int NUM_COLS = 3;
  localparam int NUM_ROWS = 2;
  localparam int CNT_W    = 16;
  localparam logic [SUM_W-1:0] AllOnes = '1;

  logic             Clk = 1'b0;
  logic             Reset;
  logic             Start;
  logic             Abort;
  logic             SumValid;
  logic [SUM_W-1:0] Sum;
  logic             Busy;
  logic             Done;
  logic [SUM_W-1:0] MinSum;
  logic [IDX_W-1:0] MinRow;
  logic [IDX_W-1:0] MinCol;
  logic [CNT_W-1:0] Count;

  sad_min_tracker #(
    .SUM_W(SUM_W), .IDX_W(IDX_W), .NUM_COLS(NUM_COLS), .NUM_ROWS(NUM_ROWS), .CNT_W(CNT_W)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Abort(Abort), .SumValid(SumValid), .Sum(Sum),
    .Busy(Busy), .Done(Done), .MinSum(MinSum), .MinRow(MinRow), .MinCol(MinCol), .Count(Count)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string            tag;
    logic             done;
    logic [SUM_W-1:0] minSum;
    logic [IDX_W-1:0] minRow;
    logic [IDX_W-1:0] minCol;
    logic [CNT_W-1:0] count;
  } exp_t;

  exp_t sb[$];
  int   nChecks = 0;
  int   nFails  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expectStart(input string tag);
    exp_t e;
    e.tag = {tag, "/start"}; e.done = 1'b0; e.minSum = AllOnes;
    e.minRow = '0; e.minCol = '0; e.count = '0;
    sb.push_back(e);
  endtask

  task automatic expectEnd(input string tag, input logic done, input logic [SUM_W-1:0] s,
                           input int r, input int c, input int n);
    exp_t e;
    e.tag = {tag, "/end"}; e.done = done; e.minSum = s;
    e.minRow = IDX_W'(r); e.minCol = IDX_W'(c); e.count = CNT_W'(n);
    sb.push_back(e);
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  initial begin
    logic prevBusy;
    exp_t e;
    prevBusy = 1'b0;
    forever begin
      @(negedge Clk);
      if (Busy !== prevBusy) begin
        if (sb.size() == 0) begin
          check("unexpectedBusyEdge", {63'd0, Busy}, {63'd0, prevBusy});
        end else begin
          e = sb.pop_front();
          check({e.tag, ".Done"},   {63'd0, Done}, {63'd0, e.done});
          check({e.tag, ".MinSum"}, 64'(MinSum),   64'(e.minSum));
          check({e.tag, ".MinRow"}, 64'(MinRow),   64'(e.minRow));
          check({e.tag, ".MinCol"}, 64'(MinCol),   64'(e.minCol));
          check({e.tag, ".Count"},  64'(Count),    64'(e.count));
        end
      end else if (!Busy) begin
        check("spuriousDone", {63'd0, Done}, 64'd0);
      end
      prevBusy = Busy;
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic startScan(input string tag);
    expectStart(tag);
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  task automatic send(input logic [SUM_W-1:0] s);
    SumValid = 1'b1;
    Sum      = s;
    tick();
    SumValid = 1'b0;
  endtask

  task automatic idle(input int n);
    SumValid = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d records pending", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1; Start = 1'b0; Abort = 1'b0; SumValid = 1'b0; Sum = '0;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    check("reset.Busy",   {63'd0, Busy}, 64'd0);
    check("reset.Done",   {63'd0, Done}, 64'd0);
    check("reset.MinSum", 64'(MinSum),   64'(AllOnes));
    check("reset.MinRow", 64'(MinRow),   64'd0);
    check("reset.MinCol", 64'(MinCol),   64'd0);
    check("reset.Count",  64'(Count),    64'd0);

    // Samples offered in IDLE are ignored.
    tick();
    for (int i = 0; i < 3; i++) send('0);
    idle(1);
    check("idleIgnore.MinSum", 64'(MinSum), 64'(AllOnes));
    check("idleIgnore.Count",  64'(Count),  64'd0);
    check("idleIgnore.Busy",   {63'd0, Busy}, 64'd0);

    // Reset in the middle of a scan.
    startScan("resetMid");
    send(32'd5);
    send(32'd6);
    expectEnd("resetMid", 1'b0, AllOnes, 0, 0, 0);
    Reset = 1'b1;
    @(negedge Clk);
    #1 Reset = 1'b0;
    tick();

    // Back-to-back samples, minimum at (1,1).
    startScan("b2b");
    expectEnd("b2b", 1'b1, 32'd2, 1, 1, 6);
    send(32'd9); send(32'd4); send(32'd7); send(32'd4); send(32'd2); send(32'd8);
    idle(3);

    // Gapped samples with ties: earliest (0,1) wins.
    startScan("gaps");
    expectEnd("gaps", 1'b1, 32'd3, 0, 1, 6);
    send(32'd5); idle(1); send(32'd3); send(32'd3); idle(2);
    send(32'd6); send(32'd3); idle(1); send(32'd9);
    idle(3);

    // Abort after three samples; the coincident sample is dropped.
    startScan("abort");
    expectEnd("abort", 1'b0, 32'd1, 0, 1, 3);
    send(32'd8); send(32'd1); send(32'd6);
    Abort = 1'b1; SumValid = 1'b1; Sum = '0;
    tick();
    Abort = 1'b0; SumValid = 1'b0;
    idle(2);
    Abort = 1'b1;
    tick();
    Abort = 1'b0;
    idle(1);
    check("abortIdle.Count", 64'(Count), 64'd3);

    // All sums all-ones: reset minimum kept, position stays (0,0).
    startScan("allOnes");
    expectEnd("allOnes", 1'b1, AllOnes, 0, 0, 6);
    for (int i = 0; i < 6; i++) send(AllOnes);
    idle(3);

    // Start in the Done cycle restarts immediately; Start during SCAN is ignored.
    startScan("chainA");
    expectEnd("chainA", 1'b1, 32'd2, 1, 2, 6);
    send(32'd7); send(32'd6); send(32'd5); send(32'd4); send(32'd3); send(32'd2);
    check("chainA.DoneCycle", {63'd0, Done}, 64'd1);
    startScan("chainB");
    expectEnd("chainB", 1'b1, 32'd1, 1, 0, 6);
    send(32'd5); send(32'd6);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    check("ignoreStart.Count", 64'(Count), 64'd2);
    send(32'd7); send(32'd1); send(32'd8); send(32'd1);
    idle(2);

    // Results held in IDLE despite further samples.
    for (int i = 0; i < 3; i++) send('0);
    idle(1);
    check("hold.MinSum", 64'(MinSum), 64'd1);
    check("hold.MinRow", 64'(MinRow), 64'd1);
    check("hold.MinCol", 64'(MinCol), 64'd0);
    check("hold.Count",  64'(Count),  64'd6);

    idle(2);
    check("scoreboardDrained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
    $finish;
  end

endmodule
